// File: rtl/pixel_readout_capture_pkg.sv
// Shared types and constants for the camera strobe receiver: frame FSM states and row tags.
package pixel_readout_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXPOSE  = 3'd1,
        ST_WAIT_R1 = 3'd2,
        ST_ROW1    = 3'd3,
        ST_WAIT_R2 = 3'd4,
        ST_ROW2    = 3'd5,
        ST_END     = 3'd6
    } cap_state_t;

    localparam logic ROW_1 = 1'b0;
    localparam logic ROW_2 = 1'b1;

    localparam int EXP_W_DEFAULT = 5;

    // States in which an early erase aborts the frame.
    function automatic logic is_active(cap_state_t s);
        return (s != ST_IDLE) && (s != ST_END);
    endfunction

endpackage

// File: rtl/pixel_readout_capture_sync_fifo.sv
// Small synchronous FIFO holding tagged ADC samples; power-of-two depth, wrapping pointers.
module pixel_readout_capture_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_readout_capture.sv
// Camera strobe receiver: frame sequencing FSM, exposure measurement, per-row ADC capture
// into a tagged sample FIFO, and sticky sequencing/overflow error flags.
module pixel_readout_capture
    import pixel_readout_capture_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int EXP_W      = EXP_W_DEFAULT,
    parameter int FRAME_W    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               expose,
    input  logic               erase,
    input  logic               nre1,
    input  logic               nre2,
    input  logic               adc,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               err_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_row,
    output logic [FRAME_W-1:0] out_frame,
    output logic [EXP_W-1:0]   exp_cycles,
    output logic               frame_done,
    output logic               frame_abort,
    output logic               err_protocol,
    output logic               err_overflow
);

    // state      | meaning
    // ST_IDLE    | waiting for expose with erase released
    // ST_EXPOSE  | counting exposure cycles
    // ST_WAIT_R1 | exposure over, waiting for nre1 low
    // ST_ROW1    | row 1 read window, one sample allowed
    // ST_WAIT_R2 | waiting for nre2 low
    // ST_ROW2    | row 2 read window, one sample allowed
    // ST_END     | readout complete, waiting for erase

    localparam int ENTRY_W = DATA_W + 1 + FRAME_W;

    cap_state_t                  state;
    logic [EXP_W-1:0]            exp_cnt;
    logic [FRAME_W-1:0]          frame_id;
    logic                        row_taken;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [ENTRY_W-1:0]          fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic in_row;
    logic cur_row;
    logic abort;
    logic both_low;
    logic sample_ok;
    logic pop_req;
    logic nre_err;
    logic miss_err;
    logic proto_err;
    logic ovf_err;

    always_comb begin
        in_row    = (state == ST_ROW1) || (state == ST_ROW2);
        cur_row   = (state == ST_ROW2) ? ROW_2 : ROW_1;
        abort     = erase && is_active(state);
        both_low  = !nre1 && !nre2;
        sample_ok = adc && in_row && !row_taken;
        pop_req   = out_valid && out_ready;
        nre_err   = both_low
                  || (!nre1 && (state != ST_WAIT_R1) && (state != ST_ROW1))
                  || (!nre2 && (state != ST_WAIT_R2) && (state != ST_ROW2));
        // Row closed without ever seeing its sample.
        miss_err  = !abort && !row_taken && !sample_ok
                  && (((state == ST_ROW1) && nre1) || ((state == ST_ROW2) && nre2));
        proto_err = (adc && !sample_ok) || nre_err || miss_err
                  || (expose && (state != ST_IDLE) && (state != ST_EXPOSE));
        ovf_err   = sample_ok && fifo_full && !pop_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            exp_cnt      <= '0;
            exp_cycles   <= '0;
            frame_id     <= '0;
            row_taken    <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            err_protocol <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            err_protocol <= proto_err || (err_protocol && !err_clr);
            err_overflow <= ovf_err || (err_overflow && !err_clr);

            if (sample_ok) begin
                row_taken <= 1'b1;
            end
            if ((state == ST_EXPOSE) && expose && (exp_cnt != '1)) begin
                exp_cnt <= exp_cnt + 1'b1;
            end

            if (abort) begin
                state       <= ST_IDLE;
                frame_abort <= 1'b1;
                frame_id    <= frame_id + 1'b1;
            end else if (!both_low) begin
                case (state)
                    ST_IDLE: begin
                        if (expose && !erase) begin
                            state   <= ST_EXPOSE;
                            exp_cnt <= EXP_W'(1);
                        end
                    end
                    ST_EXPOSE: begin
                        if (!expose) begin
                            state      <= ST_WAIT_R1;
                            exp_cycles <= exp_cnt;
                        end
                    end
                    ST_WAIT_R1: begin
                        if (!nre1) begin
                            state     <= ST_ROW1;
                            row_taken <= 1'b0;
                        end
                    end
                    ST_ROW1: begin
                        if (nre1) begin
                            state <= ST_WAIT_R2;
                        end
                    end
                    ST_WAIT_R2: begin
                        if (!nre2) begin
                            state     <= ST_ROW2;
                            row_taken <= 1'b0;
                        end
                    end
                    ST_ROW2: begin
                        if (nre2) begin
                            state <= ST_END;
                        end
                    end
                    ST_END: begin
                        if (erase) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                            frame_id   <= frame_id + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    pixel_readout_capture_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (sample_ok),
        .push_data ({frame_id, cur_row, adc_data}),
        .pop       (pop_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign out_row   = fifo_empty ? 1'b0 : fifo_head[DATA_W];
    assign out_frame = fifo_empty ? '0 : fifo_head[ENTRY_W-1 -: FRAME_W];

endmodule
